obc_dft_seq: RTL and testbench
==============================

// Module: obc_dft_seq
// PURPOSE
// - Bit-serial sequencer for the OBC distributed-arithmetic 16-point DFT.
// - Buffers one frame of 16 two's-complement samples and walks them LSB-first,
//   one bit-plane per cycle, into the combinational coefficient ROM bank.
// - Accumulates the ROM partial sums with shift-add, handles the MSB (sign) plane,
//   adds the OBC offset term and emits one result per bin.
// - Sits between the sample source and the DFT output stage; it is the only
//   driver of the ROM bank address bits and bin select.
// PARAMETERS
// - W        16  sample width, two's complement (bit-planes per bin)
// - NBINS    16  bin/ROM-set count sequenced per frame
// - RW       32  ROM word width: Q10.21 plus sign, as stored in the ROM bank
// - GB        4  accumulator guard bits; ACC_W = RW + GB
// PORTS
// - clk         in   1      rising-edge clock
// - rst_n       in   1      asynchronous active-low reset
// - s_valid     in   1      sample offered
// - s_data      in   W      sample, two's complement
// - s_ready     out  1      sample accepted when s_valid & s_ready
// - rom_bits    out  16     bit j of samples 0..15 (bit k = sample k) to ROM bank
// - rom_bin     out  $clog2(NBINS)  ROM set / bin select
// - rom_sum     in   RW     summed ROM partial value for rom_bits/rom_bin (comb, 0 latency)
// - rom_offset  in   RW     OBC offset term for rom_bin (comb)
// - m_valid     out  1      result valid
// - m_bin       out  $clog2(NBINS)  bin index of m_data
// - m_data      out  ACC_W  bin result, Q(10+GB).21 signed
// - m_ready     in   1      result consumed when m_valid & m_ready
// - busy        out  1      high in any state but IDLE
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE, s_ready=0, m_valid=0, m_data=0, m_bin=0,
//   rom_bits=0, rom_bin=0, busy=0, counters and accumulator cleared.
// - FSM: IDLE -> LOAD (next cycle after reset release) -> RUN -> OUT -> RUN | LOAD.
// - LOAD: s_ready=1; each handshake writes sample buffer[cnt], cnt 0..15.
//   The 16th handshake -> RUN with bin=0, j=0, acc=0. s_ready drops the cycle after.
// - RUN: rom_bits[k]=buffer[k][j], rom_bin=bin; one bit-plane per cycle, W cycles.
//   - j<W-1: acc <= (acc + sext(rom_sum)) >>> 1 (arithmetic; the LSB is dropped).
//   - j=W-1: m_data <= acc - sext(rom_sum) + sext(rom_offset); m_bin <= bin;
//     m_valid <= 1; -> OUT.
//   - rom_bits is 0 outside RUN.
// - OUT: m_data/m_bin held stable while m_valid & !m_ready.
//   - On handshake, m_valid <= 0 in the same edge.
//   - If bin<NBINS-1: bin++, j=0, acc=0 -> RUN.
//   - Else: -> LOAD for the next frame.
// - Latency: first sample -> first result = 16 + W cycles min.
//   Each further bin = W + 1 cycles min.
// - Backpressure: RUN never stalls; only OUT waits on m_ready. No sample is
//   accepted outside LOAD (s_valid ignored, s_ready=0).
// - Wrap: j and bin counters never exceed W-1 / NBINS-1; bin returns to 0 on frame end.
// - Width: all adds in ACC_W signed, no saturation; GB guarantees no overflow for
//   |rom_sum|,|rom_offset| < 2^(RW-1).
// - Reset mid-frame: the frame is discarded, partial buffer is invalid, and the
//   block returns to the reset state immediately.
// TESTING
// - Reset: rst_n=0 in OUT with m_valid=1 -> m_valid, s_ready, busy, rom_bits = 0 async;
//   LOAD one cycle after release.
// - Impulse: sample0=16'h0001, others 0, rom model = ROM bank sum table
//   -> each bin m_data = bit-exact golden OBC model, m_bin = 0..15 in order.
// - Sign plane: all samples 16'h8000 -> rom_bits=16'hFFFF only at j=15, 16'h0000
//   for j=0..14; result = offset - rom_sum(all ones).
// - Backpressure: m_ready=0 for 5 cycles at bin 3 -> m_data/m_bin stable,
//   no rom_bits activity, bin 4 starts the cycle after the handshake.
// - Load gaps: s_valid toggling 1010... -> exactly 16 samples captured in order;
//   s_valid during RUN is ignored.
// - Back-to-back frames: m_ready=1 constantly -> frame 2 LOAD starts right after
//   bin 15; per-bin spacing is exactly W+1 cycles.

Source files
------------

// File: rtl/obc_dft_seq.sv
// Bit-serial sequencer for the OBC distributed-arithmetic 16-point DFT.
// Buffers one frame of 16 samples, walks bit-planes LSB-first into the ROM
// bank, shift-accumulates the partial sums and emits one result per bin.
module obc_dft_seq #(
  parameter int unsigned W     = 16,
  parameter int unsigned NBINS = 16,
  parameter int unsigned RW    = 32,
  parameter int unsigned GB    = 4,
  localparam int unsigned ACC_W = RW + GB,
  localparam int unsigned BW    = $clog2(NBINS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  input  logic [W-1:0]     s_data,
  output logic             s_ready,
  output logic [15:0]      rom_bits,
  output logic [BW-1:0]    rom_bin,
  input  logic [RW-1:0]    rom_sum,
  input  logic [RW-1:0]    rom_offset,
  output logic             m_valid,
  output logic [BW-1:0]    m_bin,
  output logic [ACC_W-1:0] m_data,
  input  logic             m_ready,
  output logic             busy
);

  localparam int unsigned NS = 16;
  localparam int unsigned CW = $clog2(NS);
  localparam int unsigned JW = $clog2(W);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, OUT} state_t;

  state_t                  state, state_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [JW-1:0]           j, j_n;
  logic [BW-1:0]           bin, bin_n;
  logic signed [ACC_W-1:0] acc, acc_n;
  logic [W-1:0]            buffer   [NS];
  logic [W-1:0]            buffer_n [NS];
  logic                    m_valid_n;
  logic [BW-1:0]           m_bin_n;
  logic [ACC_W-1:0]        m_data_n;
  logic                    s_ready_n;
  logic                    busy_n;
  logic [15:0]             rom_bits_n;
  logic [BW-1:0]           rom_bin_n;
  logic signed [ACC_W-1:0] sum_x, off_x;

  // Sign-extend the ROM words to accumulator width
  assign sum_x = {{GB{rom_sum[RW-1]}}, rom_sum};
  assign off_x = {{GB{rom_offset[RW-1]}}, rom_offset};

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      j        <= '0;
      bin      <= '0;
      acc      <= '0;
      for (int k = 0; k < NS; k++) buffer[k] <= '0;
      m_valid  <= 1'b0;
      m_bin    <= '0;
      m_data   <= '0;
      s_ready  <= 1'b0;
      busy     <= 1'b0;
      rom_bits <= '0;
      rom_bin  <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      j        <= j_n;
      bin      <= bin_n;
      acc      <= acc_n;
      buffer   <= buffer_n;
      m_valid  <= m_valid_n;
      m_bin    <= m_bin_n;
      m_data   <= m_data_n;
      s_ready  <= s_ready_n;
      busy     <= busy_n;
      rom_bits <= rom_bits_n;
      rom_bin  <= rom_bin_n;
    end
  end

  // Next-state, datapath update and look-ahead of the registered outputs
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    j_n       = j;
    bin_n     = bin;
    acc_n     = acc;
    buffer_n  = buffer;
    m_valid_n = m_valid;
    m_bin_n   = m_bin;
    m_data_n  = m_data;

    case (state)
      IDLE: state_n = LOAD;
      LOAD: begin
        if (s_valid && s_ready) begin
          buffer_n[cnt] = s_data;
          cnt_n         = cnt + CW'(1);
          if (cnt == CW'(NS - 1)) begin
            state_n = RUN;
            cnt_n   = '0;
            bin_n   = '0;
            j_n     = '0;
            acc_n   = '0;
          end
        end
      end
      RUN: begin
        if (j == JW'(W - 1)) begin
          // Sign plane carries negative weight; offset completes the OBC sum
          m_data_n  = acc - sum_x + off_x;
          m_bin_n   = bin;
          m_valid_n = 1'b1;
          j_n       = '0;
          state_n   = OUT;
        end else begin
          acc_n = (acc + sum_x) >>> 1;
          j_n   = j + JW'(1);
        end
      end
      OUT: begin
        if (m_ready) begin
          m_valid_n = 1'b0;
          if (bin == BW'(NBINS - 1)) begin
            bin_n   = '0;
            cnt_n   = '0;
            state_n = LOAD;
          end else begin
            bin_n   = bin + BW'(1);
            j_n     = '0;
            acc_n   = '0;
            state_n = RUN;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    s_ready_n  = (state_n == LOAD);
    busy_n     = (state_n != IDLE);
    rom_bin_n  = bin_n;
    rom_bits_n = '0;
    if (state_n == RUN) begin
      for (int k = 0; k < NS; k++) rom_bits_n[k] = buffer_n[k][j_n];
    end
  end

endmodule

// File: tb/tb_obc_dft_seq.sv
// Directed bench for obc_dft_seq: table of frames with hand-computed bin
// results, a linear ROM model and checks on timing, backpressure and reset.
module tb_obc_dft_seq;

  localparam int W = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic [15:0] rom_bits;
  logic [3:0]  rom_bin;
  logic [31:0] rom_sum;
  logic [31:0] rom_offset;
  logic        m_valid;
  logic [3:0]  m_bin;
  logic [35:0] m_data;
  logic        m_ready;
  logic        busy;

  obc_dft_seq dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .rom_bits(rom_bits), .rom_bin(rom_bin),
    .rom_sum(rom_sum), .rom_offset(rom_offset),
    .m_valid(m_valid), .m_bin(m_bin), .m_data(m_data), .m_ready(m_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM bank model: coef(k,bin) = (bin+1)*(k+1)*2^16, offset(bin) = 3*bin-7
  longint rs;
  always_comb begin
    rs = 0;
    for (int k = 0; k < 16; k++)
      if (rom_bits[k]) rs = rs + (longint'(rom_bin) + 1) * longint'(k + 1);
    rom_sum    = 32'(rs * 65536);
    rom_offset = 32'(longint'(rom_bin) * 3 - 7);
  end

  int tests = 0;
  int fails = 0;

  bit mon_en = 1'b0;
  int nz_cnt, nz_bad;
  always @(negedge clk) begin
    if (mon_en && rom_bits != 16'h0000) begin
      nz_cnt++;
      if (rom_bits != 16'hFFFF) nz_bad++;
    end
  end

  typedef struct {
    logic [255:0] samp;
    longint       exp0;
    longint       exp15;
    bit           gaps;
    bit           bp;
    bit           junk;
    bit           mon;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
    end
  endtask

  // Exact linear DFT-bin value for the ROM model above
  function automatic longint model(input logic [255:0] sv, input int b);
    longint t;
    t = 0;
    for (int k = 0; k < 16; k++) t = t + longint'(k + 1) * longint'($signed(sv[k*16 +: 16]));
    return 2 * longint'(b + 1) * t + 3 * b - 7;
  endfunction

  task automatic load_frame(input vec_t v, output int unsigned exp_cyc, output bit ok);
    int idx;
    int to;
    bit ph;
    idx = 0; to = 0; ph = 1'b1; exp_cyc = 0;
    while (idx < 16 && to < 200) begin
      @(negedge clk);
      to++;
      s_valid = v.gaps ? ph : 1'b1;
      ph      = !ph;
      s_data  = v.samp[idx*16 +: 16];
      if (s_valid && s_ready) begin
        idx++;
        exp_cyc = cyc + 1 + W;
      end
    end
    ok = (idx == 16);
    check("load_complete", idx, 16);
    @(negedge clk);
    s_valid = v.junk;
    s_data  = 16'hA5A5;
    if (ok) check("s_ready_in_run", s_ready, 0);
  endtask

  task automatic run_frame(input vec_t v);
    int unsigned exp_cyc;
    bit ok;
    int to;
    logic [35:0] hold_d;
    logic [3:0]  hold_b;
    load_frame(v, exp_cyc, ok);
    if (!ok) return;
    for (int b = 0; b < 16; b++) begin
      to = 0;
      do begin @(negedge clk); to++; end while (!m_valid && to < 400);
      check("m_valid_seen", m_valid, 1);
      if (!m_valid) return;
      check("m_bin", m_bin, b);
      check("m_data", $signed(m_data), (b == 0) ? v.exp0 : (b == 15) ? v.exp15 : model(v.samp, b));
      check("bin_spacing", cyc, exp_cyc);
      if (v.junk) check("s_ready_low_busy", s_ready, 0);
      if (b == 15) s_valid = 1'b0;
      if (v.bp && b == 3) begin
        hold_d = m_data;
        hold_b = m_bin;
        repeat (5) begin
          @(negedge clk);
          check("bp_valid", m_valid, 1);
          check("bp_data", m_data, hold_d);
          check("bp_bin", m_bin, hold_b);
          check("bp_rom_bits", rom_bits, 0);
        end
        m_ready = 1'b1;
      end
      exp_cyc = cyc + 1 + W;
      if (v.bp && b == 2) begin
        @(negedge clk);
        m_ready = 1'b0;
      end
    end
    @(negedge clk);
    check("load_after_bin15", s_ready, 1);
  endtask

  initial begin
    int unsigned ec;
    bit ok;
    int to;
    logic [255:0] ramp;

    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    for (int k = 0; k < 16; k++) ramp[k*16 +: 16] = 16'(k);
    vecs[0] = '{samp: 256'd1, exp0: -5, exp15: 70,
                gaps: 1'b0, bp: 1'b0, junk: 1'b0, mon: 1'b0};
    vecs[1] = '{samp: {16{16'h8000}}, exp0: -8912903, exp15: -142606298,
                gaps: 1'b0, bp: 1'b0, junk: 1'b0, mon: 1'b1};
    vecs[2] = '{samp: ramp, exp0: 2713, exp15: 43558,
                gaps: 1'b1, bp: 1'b1, junk: 1'b0, mon: 1'b0};
    vecs[3] = '{samp: {256{1'b1}}, exp0: -279, exp15: -4314,
                gaps: 1'b0, bp: 1'b0, junk: 1'b1, mon: 1'b0};
    vecs[4] = '{samp: {16'h7FFF, 240'd0}, exp0: 1048537, exp15: 16776742,
                gaps: 1'b0, bp: 1'b0, junk: 1'b0, mon: 1'b0};

    #12;
    check("rst_m_valid", m_valid, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rom_bits", rom_bits, 0);
    check("rst_rom_bin", rom_bin, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_bin", m_bin, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("idle_s_ready", s_ready, 0);
    check("idle_busy", busy, 0);
    @(negedge clk);
    check("load_s_ready", s_ready, 1);
    check("load_busy", busy, 1);

    for (int i = 0; i < 5; i++) begin
      nz_cnt = 0; nz_bad = 0;
      mon_en = vecs[i].mon;
      run_frame(vecs[i]);
      mon_en = 1'b0;
      if (vecs[i].mon) begin
        check("sign_plane_cycles", nz_cnt, 16);
        check("sign_plane_pattern", nz_bad, 0);
      end
    end

    // Reset while a result is pending in OUT
    m_ready = 1'b0;
    load_frame(vecs[0], ec, ok);
    to = 0;
    do begin @(negedge clk); to++; end while (!m_valid && to < 400);
    check("pre_reset_valid", m_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_m_valid", m_valid, 0);
    check("arst_s_ready", s_ready, 0);
    check("arst_busy", busy, 0);
    check("arst_rom_bits", rom_bits, 0);
    check("arst_m_data", m_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    check("load_after_reset", s_ready, 1);
    run_frame(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
